integrated_top_module: RTL and testbench
========================================

INTEGRATED_TOP_MODULE -- requirements
Module: integrated_top_module

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports Switch_A and Switch_B, inputs, 4 bits each: the multiplicand and multiplier operands.
REQ-004 SHALL have ports Reg_A and Reg_B, outputs, 4 bits each: the operand registers.
REQ-005 SHALL have ports MUX1, Shifter, MUX2, ALU, ACC and Output_Reg, outputs, 8 bits each: the datapath node values.
REQ-006 SHALL have port Flag, output, 1 bit: the multiplier bit under test, equal to Reg_B[0].
REQ-007 SHALL have port PC_out, output, 5 bits: the program counter.
REQ-008 SHALL have port IR_out, output, 4 bits: the current opcode, a combinational lookup of ROM[PC].
REQ-009 SHALL have port control, output, 16 bits: the combinational decode of IR_out.

Function
REQ-010 SHALL hold a fixed 32-entry program ROM with 4-bit opcodes. The instruction at PC executes on the next rising edge, and PC then increments by 1.
REQ-011 Opcodes SHALL be:
- 0000 NOP.
- 0001 LOAD: Reg_A<=Switch_A, Reg_B<=Switch_B.
- 0010 CLR: ACC<=0, Shifter<=0.
- 0011 LDSH: Shifter<=MUX1, with MUX1 selecting Reg_A.
- 0100 ADDC: ACC<=ALU.
- 0101 SHL: Shifter<=MUX1<<1 (MUX1 selecting Shifter), Reg_B<=Reg_B>>1 with zero fill.
- 0110 OUT: Output_Reg<=ACC.
- 0111 HALT: PC holds and no register changes.
- 1000-1111: behave as NOP.
REQ-012 Control bits SHALL be:
- [0] LOAD, [1] CLR, [2] LDSH, [3] SHL, [4] ADD_EN, [5] OUT_EN, [6] HALT.
- [7] MUX1_SEL (1 = Shifter, 0 = {4'b0,Reg_A}).
- [15:8] SHALL be 0.
- control SHALL be all-zero for NOP.
REQ-013 MUX1 SHALL equal MUX1_SEL ? Shifter : {4'b0000,Reg_A}.
REQ-014 MUX2 SHALL equal Flag ? Shifter : 8'h00.
REQ-015 ALU SHALL equal ACC+MUX2, truncated to 8 bits (mod 256).
REQ-016 The ROM contents SHALL be:
- PC 0-7: NOP (operand settling window).
- PC 8: LOAD. PC 9: CLR. PC 10: LDSH.
- PC 11: ADDC. PC 12: SHL. PC 13: ADDC. PC 14: SHL. PC 15: ADDC. PC 16: SHL. PC 17: ADDC.
- PC 18: OUT. PC 19-30: NOP. PC 31: HALT.
REQ-017 After PC 18 executes, Output_Reg SHALL equal (Switch_A×Switch_B) as sampled at the LOAD edge, in unsigned 8 bits. The maximum result is 225, so no overflow occurs.
REQ-018 Switch changes after the LOAD edge SHALL NOT affect Reg_A, Reg_B or the result.
REQ-019 PC SHALL remain at 31 indefinitely until reset. PC SHALL never wrap from 31 to 0.
REQ-020 On the first edge after reset deasserts, the instruction at PC 0 SHALL execute. The LOAD therefore occurs on the 9th post-reset edge.
REQ-021 All non-ROM state SHALL be registers clocked only by clk. No latches.

Reset
REQ-022 When reset=1 at a rising edge, the following SHALL all become 0: PC, Reg_A, Reg_B, Shifter, ACC and Output_Reg.
REQ-023 Reset SHALL take priority over any executing instruction, including HALT.
REQ-024 A reset mid-program SHALL restart execution from PC 0 on the next post-reset edge.
REQ-025 During and immediately after reset, the following SHALL be 0: Flag, MUX1, MUX2 and ALU. IR_out and control SHALL be those of PC 0 (NOP).

Verification
REQ-026 Reset 1 cycle; Switch_A=10 and Switch_B=10 applied before PC 8 -> at PC_out=31, Output_Reg=100 (0x64) and ACC=100.
REQ-027 Switch_A=15, Switch_B=15 -> Output_Reg=225 (0xE1) at PC 31; no wrap.
REQ-028 Switch_A=0, Switch_B=7, and also Switch_A=9, Switch_B=0 -> Output_Reg=0 at PC 31.
REQ-029 Switch_A=3, Switch_B=5 loaded; switches changed to 15/15 at PC 12 -> Output_Reg=15.
REQ-030 Assert reset while PC=13 mid-multiply -> PC, ACC, Shifter and Output_Reg are 0 next edge; after release, the run completes with the correct product.
REQ-031 Hold 20 cycles after reaching PC 31 -> PC_out stays 31, Output_Reg unchanged, control=0x0040.

Source files
------------

// File: rtl/integrated_top_module.sv
// -----------------------------------------------------------------------------
// integrated_top_module
//
// Microprogrammed 4x4 unsigned shift-and-add multiplier. A fixed 32-entry
// opcode ROM, indexed by the program counter, sequences a small datapath:
// operand registers, a shifter, an accumulator and an output register. After
// one pass through the program, Output_Reg holds Switch_A * Switch_B as
// captured by the LOAD instruction. The program ends on a HALT at PC 31 and
// stays there until reset.
//
// Ports
//   clk          in   1  system clock; all state updates on the rising edge
//   reset        in   1  synchronous, active-high reset
//   Switch_A     in   4  multiplicand operand
//   Switch_B     in   4  multiplier operand
//   Reg_A        out  4  multiplicand register
//   Reg_B        out  4  multiplier register, shifted right one bit per SHL
//   MUX1         out  8  shifter source: Shifter or {4'b0, Reg_A}
//   Shifter      out  8  shifted partial-product register
//   MUX2         out  8  addend: Shifter when Flag is set, otherwise zero
//   ALU          out  8  ACC + MUX2, modulo 256
//   ACC          out  8  accumulator
//   Output_Reg   out  8  result register, written by OUT
//   Flag         out  1  multiplier bit under test (Reg_B[0])
//   PC_out       out  5  program counter
//   IR_out       out  4  opcode at the current PC (combinational ROM read)
//   control      out 16  decoded control word for IR_out
// -----------------------------------------------------------------------------
module integrated_top_module (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Switch_A,
    input  logic [3:0]  Switch_B,
    output logic [3:0]  Reg_A,
    output logic [3:0]  Reg_B,
    output logic [7:0]  MUX1,
    output logic [7:0]  Shifter,
    output logic [7:0]  MUX2,
    output logic [7:0]  ALU,
    output logic [7:0]  ACC,
    output logic [7:0]  Output_Reg,
    output logic        Flag,
    output logic [4:0]  PC_out,
    output logic [3:0]  IR_out,
    output logic [15:0] control
);

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;
    localparam int PC_W   = 5;

    // Opcodes
    localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_LOAD = 4'b0001;
    localparam logic [OP_W-1:0] OP_CLR  = 4'b0010;
    localparam logic [OP_W-1:0] OP_LDSH = 4'b0011;
    localparam logic [OP_W-1:0] OP_ADDC = 4'b0100;
    localparam logic [OP_W-1:0] OP_SHL  = 4'b0101;
    localparam logic [OP_W-1:0] OP_OUT  = 4'b0110;
    localparam logic [OP_W-1:0] OP_HALT = 4'b0111;

    // Control word bit positions
    localparam int C_LOAD     = 0;
    localparam int C_CLR      = 1;
    localparam int C_LDSH     = 2;
    localparam int C_SHL      = 3;
    localparam int C_ADD_EN   = 4;
    localparam int C_OUT_EN   = 5;
    localparam int C_HALT     = 6;
    localparam int C_MUX1_SEL = 7;

    // -------------------------------------------------------------------------
    // Program ROM. PC 0-7 are idle so the operand switches can settle before
    // LOAD; PC 11-17 unroll the four add/shift steps of the multiply.
    // -------------------------------------------------------------------------
    function automatic logic [OP_W-1:0] rom_read(input logic [PC_W-1:0] addr);
        logic [OP_W-1:0] op;
        op = OP_NOP;
        case (addr)
            5'd8:    op = OP_LOAD;
            5'd9:    op = OP_CLR;
            5'd10:   op = OP_LDSH;
            5'd11:   op = OP_ADDC;
            5'd12:   op = OP_SHL;
            5'd13:   op = OP_ADDC;
            5'd14:   op = OP_SHL;
            5'd15:   op = OP_ADDC;
            5'd16:   op = OP_SHL;
            5'd17:   op = OP_ADDC;
            5'd18:   op = OP_OUT;
            5'd31:   op = OP_HALT;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    // Opcode to control word. Opcodes 1000-1111 fall through to all-zero,
    // which makes them indistinguishable from NOP.
    function automatic logic [15:0] decode_op(input logic [OP_W-1:0] op);
        logic [15:0] c;
        c = 16'h0000;
        case (op)
            OP_LOAD: c[C_LOAD]   = 1'b1;
            OP_CLR:  c[C_CLR]    = 1'b1;
            OP_LDSH: c[C_LDSH]   = 1'b1;  // MUX1_SEL stays 0: source is Reg_A
            OP_ADDC: c[C_ADD_EN] = 1'b1;
            OP_SHL: begin
                c[C_SHL]      = 1'b1;
                c[C_MUX1_SEL] = 1'b1;     // shift the Shifter's own value
            end
            OP_OUT:  c[C_OUT_EN] = 1'b1;
            OP_HALT: c[C_HALT]   = 1'b1;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    // Accumulate with plain wrap-around; the product never exceeds 225 so the
    // wrap is never exercised by the program, only defined for completeness.
    function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] x,
                                                  input logic [DATA_W-1:0] y);
        return x + y;
    endfunction

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [PC_W-1:0]   r_pc;
    logic [3:0]        r_reg_a;
    logic [3:0]        r_reg_b;
    logic [DATA_W-1:0] r_shifter;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_out;

    // -------------------------------------------------------------------------
    // Fetch / decode and combinational datapath
    // -------------------------------------------------------------------------
    logic [OP_W-1:0]   w_ir;
    logic [15:0]       w_ctrl;
    logic              w_flag;
    logic [DATA_W-1:0] w_mux1;
    logic [DATA_W-1:0] w_mux2;
    logic [DATA_W-1:0] w_alu;

    always_comb begin
        w_ir   = rom_read(r_pc);
        w_ctrl = decode_op(w_ir);
        w_flag = r_reg_b[0];
        w_mux1 = w_ctrl[C_MUX1_SEL] ? r_shifter : {4'b0000, r_reg_a};
        w_mux2 = w_flag ? r_shifter : '0;
        w_alu  = add_mod(r_acc, w_mux2);
    end

    // -------------------------------------------------------------------------
    // Execute: the instruction at PC commits on this edge. Each opcode
    // asserts at most one write enable per register, so the branches below
    // never compete for the same register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else if (!w_ctrl[C_HALT]) begin
            // HALT only lives at PC 31, so the counter never wraps to 0.
            r_pc <= r_pc + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_a <= '0;
            r_reg_b <= '0;
        end else if (w_ctrl[C_LOAD]) begin
            r_reg_a <= Switch_A;
            r_reg_b <= Switch_B;
        end else if (w_ctrl[C_SHL]) begin
            // Walk the next multiplier bit into Flag.
            r_reg_b <= {1'b0, r_reg_b[3:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shifter <= '0;
        end else if (w_ctrl[C_CLR]) begin
            r_shifter <= '0;
        end else if (w_ctrl[C_LDSH]) begin
            r_shifter <= w_mux1;
        end else if (w_ctrl[C_SHL]) begin
            r_shifter <= {w_mux1[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_ctrl[C_CLR]) begin
            r_acc <= '0;
        end else if (w_ctrl[C_ADD_EN]) begin
            r_acc <= w_alu;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else if (w_ctrl[C_OUT_EN]) begin
            r_out <= r_acc;
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign Reg_A      = r_reg_a;
    assign Reg_B      = r_reg_b;
    assign MUX1       = w_mux1;
    assign Shifter    = r_shifter;
    assign MUX2       = w_mux2;
    assign ALU        = w_alu;
    assign ACC        = r_acc;
    assign Output_Reg = r_out;
    assign Flag       = w_flag;
    assign PC_out     = r_pc;
    assign IR_out     = w_ir;
    assign control    = w_ctrl;

endmodule

// File: tb/tb_integrated_top_module.sv
module tb_integrated_top_module;

    logic        clk;
    logic        reset;
    logic [3:0]  Switch_A;
    logic [3:0]  Switch_B;
    logic [3:0]  Reg_A;
    logic [3:0]  Reg_B;
    logic [7:0]  MUX1;
    logic [7:0]  Shifter;
    logic [7:0]  MUX2;
    logic [7:0]  ALU;
    logic [7:0]  ACC;
    logic [7:0]  Output_Reg;
    logic        Flag;
    logic [4:0]  PC_out;
    logic [3:0]  IR_out;
    logic [15:0] control;

    int n_cmp = 0;
    int n_bad = 0;

    integrated_top_module dut (
        .clk        (clk),
        .reset      (reset),
        .Switch_A   (Switch_A),
        .Switch_B   (Switch_B),
        .Reg_A      (Reg_A),
        .Reg_B      (Reg_B),
        .MUX1       (MUX1),
        .Shifter    (Shifter),
        .MUX2       (MUX2),
        .ALU        (ALU),
        .ACC        (ACC),
        .Output_Reg (Output_Reg),
        .Flag       (Flag),
        .PC_out     (PC_out),
        .IR_out     (IR_out),
        .control    (control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Step until PC_out reaches target; running out of budget is a failure.
    task automatic run_to_pc(input string tag, input logic [4:0] target, input int budget);
        int n;
        n = 0;
        while (PC_out !== target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {11'd0, PC_out}, {11'd0, target});
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic run_mult(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] prod);
        Switch_A = a;
        Switch_B = b;
        apply_reset();
        run_to_pc({tag, "_pc31"}, 5'd31, 40);
        chk({tag, "_out"}, {8'd0, Output_Reg}, {8'd0, prod});
        chk({tag, "_acc"}, {8'd0, ACC}, {8'd0, prod});
    endtask

    initial begin
        reset    = 1'b1;
        Switch_A = 4'd10;
        Switch_B = 4'd10;

        // ---- reset state ----
        tick();
        chk("rst_pc",    {11'd0, PC_out},     16'd0);
        chk("rst_rega",  {12'd0, Reg_A},      16'd0);
        chk("rst_regb",  {12'd0, Reg_B},      16'd0);
        chk("rst_shift", {8'd0, Shifter},     16'd0);
        chk("rst_acc",   {8'd0, ACC},         16'd0);
        chk("rst_out",   {8'd0, Output_Reg},  16'd0);
        chk("rst_flag",  {15'd0, Flag},       16'd0);
        chk("rst_mux1",  {8'd0, MUX1},        16'd0);
        chk("rst_mux2",  {8'd0, MUX2},        16'd0);
        chk("rst_alu",   {8'd0, ALU},         16'd0);
        chk("rst_ir",    {12'd0, IR_out},     16'd0);
        chk("rst_ctrl",  control,             16'h0000);
        reset = 1'b0;

        // ---- 10 x 10, stepped through the first instructions ----
        repeat (8) tick();
        chk("s_pc8",     {11'd0, PC_out},     16'd8);
        chk("s_ir8",     {12'd0, IR_out},     16'd1);
        chk("s_ctl8",    control,             16'h0001);
        tick();   // 9th post-reset edge: LOAD
        chk("s_rega",    {12'd0, Reg_A},      16'd10);
        chk("s_regb",    {12'd0, Reg_B},      16'd10);
        chk("s_ctl9",    control,             16'h0002);
        tick();   // CLR
        chk("s_ctl10",   control,             16'h0004);
        chk("s_mux1_a",  {8'd0, MUX1},        16'd10);
        tick();   // LDSH
        chk("s_shldsh",  {8'd0, Shifter},     16'd10);
        chk("s_ctl11",   control,             16'h0010);
        chk("s_flag0",   {15'd0, Flag},       16'd0);
        chk("s_alu0",    {8'd0, ALU},         16'd0);
        tick();   // ADDC with Flag=0
        chk("s_acc0",    {8'd0, ACC},         16'd0);
        chk("s_ctl12",   control,             16'h0088);
        chk("s_mux1_sh", {8'd0, MUX1},        16'd10);
        tick();   // SHL
        chk("s_shl",     {8'd0, Shifter},     16'd20);
        chk("s_regb_sh", {12'd0, Reg_B},      16'd5);
        chk("s_flag1",   {15'd0, Flag},       16'd1);
        chk("s_mux2",    {8'd0, MUX2},        16'd20);
        chk("s_alu1",    {8'd0, ALU},         16'd20);
        run_to_pc("m10_pc31", 5'd31, 40);
        chk("m10_out",   {8'd0, Output_Reg},  16'h0064);
        chk("m10_acc",   {8'd0, ACC},         16'h0064);

        // ---- HALT hold: no wrap, nothing changes ----
        repeat (20) tick();
        chk("hold_pc",   {11'd0, PC_out},     16'd31);
        chk("hold_out",  {8'd0, Output_Reg},  16'h0064);
        chk("hold_ctl",  control,             16'h0040);
        chk("hold_ir",   {12'd0, IR_out},     16'd7);

        // ---- further products ----
        run_mult("m15", 4'd15, 4'd15, 8'd225);
        repeat (3) tick();
        chk("m15_nowrap", {11'd0, PC_out},    16'd31);
        run_mult("m0x7", 4'd0, 4'd7, 8'd0);
        run_mult("m9x0", 4'd9, 4'd0, 8'd0);

        // ---- switches changed after LOAD ----
        Switch_A = 4'd3;
        Switch_B = 4'd5;
        apply_reset();
        run_to_pc("late_pc12", 5'd12, 20);
        Switch_A = 4'd15;
        Switch_B = 4'd15;
        run_to_pc("late_pc31", 5'd31, 40);
        chk("late_out",  {8'd0, Output_Reg},  16'd15);
        chk("late_rega", {12'd0, Reg_A},      16'd3);

        // ---- reset mid-multiply at PC 13 ----
        Switch_A = 4'd6;
        Switch_B = 4'd7;
        apply_reset();
        run_to_pc("mid_pc13", 5'd13, 20);
        reset = 1'b1;
        tick();
        chk("mid_pc",    {11'd0, PC_out},     16'd0);
        chk("mid_acc",   {8'd0, ACC},         16'd0);
        chk("mid_shift", {8'd0, Shifter},     16'd0);
        chk("mid_out",   {8'd0, Output_Reg},  16'd0);
        reset = 1'b0;
        tick();
        chk("mid_restart", {11'd0, PC_out},   16'd1);
        run_to_pc("mid_pc31", 5'd31, 40);
        chk("mid_prod",  {8'd0, Output_Reg},  16'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
